// File: rtl/mini_alu_core.sv
// Two-stage (fetch/execute) MiniAlu core with a return stack and a stall-capable video write port.
// Define MINI_ALU_SMUL_EN to build the signed multiplier; otherwise SMUL executes as an illegal opcode.
module mini_alu_core #(
  parameter int DATA_W      = 16,
  parameter int REG_DEPTH   = 256,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [IP_W-1:0] oIP,
  input  logic [27:0]     iInstruction,
  output logic            oVidWrite,
  input  logic            iVidReady,
  output logic [6:0]      oVidCol,
  output logic [5:0]      oVidRow,
  output logic [2:0]      oVidColor,
  output logic            oStackErr,
  output logic            oIllegal
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB  = 4'd2,  OP_STO = 4'd3,
    OP_BLE  = 4'd4,  OP_BGE = 4'd5,  OP_JMP  = 4'd6,  OP_SMUL = 4'd7,
    OP_CALL = 4'd8,  OP_RET = 4'd9,  OP_VGA  = 4'd10, OP_INC = 4'd11,
    OP_MOV  = 4'd12
  } op_e;

  localparam int RAW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [27:0]       r_exec;
  logic [IP_W-1:0]   r_ip;
  logic [IP_W-1:0]   r_stack [STACK_DEPTH];
  logic [SPW-1:0]    r_sp;
  logic              r_stack_err;
  logic [DATA_W-1:0] r_regs [REG_DEPTH];

  op_e               w_op;
  logic [7:0]        w_dst, w_src1, w_src0;
  logic [RAW-1:0]    w_ra1, w_ra0, w_wa0;
  logic [DATA_W-1:0] w_rd1, w_rd0, w_imm, w_wd0;
  logic signed [15:0] w_imm16;
  logic [SIW-1:0]    w_push_idx, w_top_idx;
  logic [IP_W-1:0]   w_target;
  logic              w_taken, w_push, w_pop, w_err_set, w_we0, w_illegal, w_vga, w_stall;

  function automatic logic [RAW-1:0] reg_idx(input int a);
    return RAW'(a % REG_DEPTH);
  endfunction

  assign w_op   = op_e'(r_exec[27:24]);
  assign w_dst  = r_exec[23:16];
  assign w_src1 = r_exec[15:8];
  assign w_src0 = r_exec[7:0];

  assign w_ra1 = reg_idx(int'(w_src1));
  assign w_ra0 = reg_idx(int'(w_src0));
  assign w_wa0 = reg_idx(int'(w_dst));
  assign w_rd1 = r_regs[w_ra1];
  assign w_rd0 = r_regs[w_ra0];

  // Size cast of a signed operand sign-extends when widening and truncates when narrowing.
  assign w_imm16 = {w_src1, w_src0};
  assign w_imm   = DATA_W'(w_imm16);

  assign w_push_idx = SIW'(r_sp);
  assign w_top_idx  = SIW'(r_sp - 1'b1);

`ifdef MINI_ALU_SMUL_EN
  logic signed [2*DATA_W-1:0] w_mul_a, w_mul_b, w_prod;
  logic [RAW-1:0]             w_wa1;
  logic                       w_we1;

  assign w_mul_a = {{DATA_W{w_rd1[DATA_W-1]}}, w_rd1};
  assign w_mul_b = {{DATA_W{w_rd0[DATA_W-1]}}, w_rd0};
  assign w_prod  = w_mul_a * w_mul_b;
  assign w_wa1   = reg_idx(int'(w_dst) + 1);
  assign w_we1   = (w_op == OP_SMUL);
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_taken   = 1'b0;
    w_target  = IP_W'(w_dst);
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    w_we0     = 1'b0;
    w_wd0     = '0;
    w_illegal = 1'b0;
    w_vga     = 1'b0;
    case (w_op)
      OP_NOP: ;
      OP_ADD: begin w_we0 = 1'b1; w_wd0 = w_rd1 + w_rd0; end
      OP_SUB: begin w_we0 = 1'b1; w_wd0 = w_rd1 - w_rd0; end
      OP_STO: begin w_we0 = 1'b1; w_wd0 = w_imm; end
      OP_BLE: w_taken = ($signed(w_rd1) <= $signed(w_rd0));
      OP_BGE: w_taken = ($signed(w_rd1) >= $signed(w_rd0));
      OP_JMP: w_taken = 1'b1;
`ifdef MINI_ALU_SMUL_EN
      OP_SMUL: begin w_we0 = 1'b1; w_wd0 = w_prod[DATA_W-1:0]; end
`endif
      OP_CALL: begin
        if (r_sp == SPW'(STACK_DEPTH)) w_err_set = 1'b1;
        else begin w_taken = 1'b1; w_push = 1'b1; end
      end
      OP_RET: begin
        w_target = r_stack[w_top_idx];
        if (r_sp == '0) w_err_set = 1'b1;
        else begin w_taken = 1'b1; w_pop = 1'b1; end
      end
      OP_VGA: w_vga = 1'b1;
      OP_INC: begin w_we0 = 1'b1; w_wd0 = w_rd1 + DATA_W'(1); end
      OP_MOV: begin w_we0 = 1'b1; w_wd0 = w_rd1; end
      default: w_illegal = 1'b1;
    endcase
  end

  // A stall is only ever a VGA, so it never coincides with a taken redirect.
  assign w_stall   = w_vga & ~iVidReady;
  assign oIP       = !Reset ? '0 : (w_taken ? w_target : r_ip);
  assign oVidWrite = Reset & w_vga;
  assign oIllegal  = Reset & w_illegal;
  assign oVidCol   = w_rd1[6:0];
  assign oVidRow   = w_rd0[5:0];
  assign oVidColor = w_dst[2:0];
  assign oStackErr = r_stack_err;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_ip        <= '0;
      r_exec      <= '0;
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else if (!w_stall) begin
      r_ip   <= oIP + IP_W'(1);
      r_exec <= iInstruction;
      if (w_push)     r_sp <= r_sp + 1'b1;
      else if (w_pop) r_sp <= r_sp - 1'b1;
      if (w_err_set)  r_stack_err <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; the stack pointer alone defines which entries are valid.
  always_ff @(posedge Clock) begin
    if (Reset && w_push) r_stack[w_push_idx] <= r_ip;
  end

  always_ff @(posedge Clock) begin
    if (Reset && w_we0) r_regs[w_wa0] <= w_wd0;
`ifdef MINI_ALU_SMUL_EN
    if (Reset && w_we1) r_regs[w_wa1] <= w_prod[2*DATA_W-1:DATA_W];
`endif
  end

endmodule

// File: doc/mini_alu_core.md
# mini_alu_core

Parametrised successor to the MiniAlu execution core: a single-issue, two-stage (fetch / execute) processor with a configurable data width, register-file depth, a nested hardware call stack and a stall-capable video write port. The block fetches 28-bit instructions from an external combinational instruction ROM and drives writes into the external video memory. It replaces the single-entry return buffer with a STACK_DEPTH-entry return stack and adds back-pressure on video writes.

## Interface
- DATA_W, 16: register and ALU width in bits, 8..32.
- REG_DEPTH, 256: registers in the internal 2-read/1-write file, 2..256. Register addresses are taken modulo REG_DEPTH.
- IP_W, 16: instruction pointer width.
- STACK_DEPTH, 4: return stack entries, 1..16.
- Clock  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- oIP  out  IP_W  fetch address to the instruction ROM.
- iInstruction  in  28  instruction at oIP, same cycle (combinational ROM).
- oVidWrite  out  1  video write request.
- iVidReady  in  1  video memory accepts the write this cycle.
- oVidCol  out  7  equals src1-data[6:0].
- oVidRow  out  6  equals src0-data[5:0].
- oVidColor  out  3  equals dst field[2:0].
- oStackErr  out  1  sticky flag for overflow or underflow; cleared only by reset.
- oIllegal  out  1  one-cycle pulse when an undefined opcode executes.

## Operation
- Instruction fields: op[27:24], dst[23:16], src1[15:8], src0[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD: R[dst] = R[src1] + R[src0].
  - 2 SUB: R[dst] = R[src1] − R[src0].
  - 3 STO: R[dst] = {src1,src0} sign-extended or truncated to DATA_W.
  - 4 BLE: branch if R[src1] ≤ R[src0], signed compare.
  - 5 BGE: branch if R[src1] ≥ R[src0], signed compare.
  - 6 JMP.
  - 7 SMUL.
  - 8 CALL.
  - 9 RET.
  - 10 VGA.
  - 11 INC: R[dst] = R[src1] + 1.
  - 12 MOV: R[dst] = R[src1].
  - 13–15: act as NOP and pulse oIllegal.
- Arithmetic wraps modulo 2^DATA_W. No flags are produced.
- Branch target is the dst field, zero-extended to IP_W.
- Execute register holds the instruction latched from iInstruction.
  - Register reads are asynchronous from execute-register fields.
  - Register write occurs at the end of the execute cycle.
- ip_q holds the next sequential fetch address.
  - oIP = target when a branch, JMP, CALL or RET is taken in execute; otherwise ip_q.
  - When not stalled: ip_q <= oIP + 1 and exec <= iInstruction.
  - There is no delay slot and no squash.
- CALL:
  - Pushes ip_q (the address after the CALL) and redirects to dst.
  - If the stack is full: no push, no branch (falls through), oStackErr <= 1.
- RET:
  - Pops the top entry into oIP.
  - If the stack is empty: no branch, oStackErr <= 1.
- VGA: oVidWrite = 1 combinationally for the whole execute cycle.
  - If iVidReady = 0, the core stalls. ip_q, exec, the stack and the register file hold, and oIP = ip_q.
  - Completes in the cycle iVidReady = 1.
- Reset (Reset = 0 at an edge):
  - ip_q = 0, exec = NOP, stack empty, oStackErr = 0.
  - Register-file contents are undefined.
  - Outputs during reset: oIP = 0, oVidWrite = 0, oIllegal = 0.
  - Reset asserted mid-stall abandons the video write.

## Timing
- Fetch-to-execute latency is 1 cycle. Throughput is 1 instruction per cycle, excluding video stalls.
- The first edge with Reset = 1 latches ROM[0]; it executes in the following cycle.
- A taken branch costs 0 bubbles: the target is fetched in the same cycle and executes in the next.
- A register written in cycle n is readable in cycle n+1. The write-to-read path is 1 cycle; no bypass is needed.
- Stack push/pop take effect at the end of the CALL/RET execute cycle.
- Back-to-back CALL then RET returns correctly.

## Configuration
- MINI_ALU_SMUL_EN defined:
  - SMUL computes the full signed 2·DATA_W product.
  - R[dst] = low DATA_W bits; R[dst+1 mod REG_DEPTH] = high DATA_W bits.
  - The second write port is implemented as a second register-file write in the same cycle.
- Undefined: SMUL is treated as an undefined opcode (no write, oIllegal pulse). No multiplier is instantiated.

## Test plan
- Reset then sequential code:
  - STO R1,5; STO R2,−3; ADD R3,R1,R2 → R3 = 2.
  - SUB R4,R2,R1 → R4 = −8 (0xFFF8 at DATA_W = 16).
  - oIP sequence 0,1,2,3.
- Branching:
  - BLE with R1 = −3, R0 = 2 at address 4, dst = 20 → oIP = 20 in the execute cycle; ROM[5] never executes.
  - BGE with the same operands → falls to 5.
- Nested calls, STACK_DEPTH = 4:
  - Four CALLs then four RETs return to each caller+1 in LIFO order.
  - A fifth CALL → no branch, oStackErr = 1.
  - RET on empty → no branch, flag stays 1 until Reset = 0.
- Video stall:
  - VGA with R[src1] = 0x4F, R[src0] = 0x3B, dst = 5 → oVidCol = 0x4F, oVidRow = 0x3B, oVidColor = 5.
  - iVidReady held low 3 cycles → oIP frozen, oVidWrite held 4 cycles, next instruction follows.
- SMUL:
  - With the macro: R1 = 300, R2 = −400 → R[dst] = 0x2B40, R[dst+1] = 0xFFFE.
  - Without the macro: no register change, oIllegal pulses once.
- Reset mid-operation: assert Reset during a VGA stall → the next cycle oVidWrite = 0, oIP = 0, stack empty.
